// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit.
// Operation encoding, default element width, amount range decision.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 12;

    typedef enum logic [1:0] {
        SHL = 2'd0,
        SHR = 2'd1,
        SAR = 2'd2,
        ROL = 2'd3
    } shift_op_t;

    // Out-of-range distance forces the full-range result.
    // Rotates never saturate; they wrap on the low amount bits.
    function automatic logic eff_amount(
        input shift_op_t op,
        input logic      over
    );
        return over && (op != ROL);
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response handshake bundle of the shift unit.
// The sequencer side is master, the shift unit is slave.
interface shift_unit_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    shift_op_t        in_op;
    logic [WIDTH-1:0] in_value;
    logic [WIDTH-1:0] in_amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_lost;

    modport master (
        output in_valid,
        output in_op,
        output in_value,
        output in_amount,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_lost
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_value,
        input  in_amount,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_lost
    );

endinterface

// File: rtl/shift_stage.sv
// One slot of the log shifter: conditional shift by DIST.
// Holds valid/op/value/amount/lost and advances with the pipe.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIST  = 1,
    parameter int AW    = 4,
    parameter int BIT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  shift_op_t        in_op,
    input  logic [WIDTH-1:0] in_value,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_lost,
    output logic             out_valid,
    input  logic             out_ready,
    output shift_op_t        out_op,
    output logic [WIDTH-1:0] out_value,
    output logic [AW-1:0]    out_amt,
    output logic             out_lost
);

    logic             valid_q;
    logic [WIDTH-1:0] dropped;
    logic [WIDTH-1:0] nxt_value;
    logic             nxt_lost;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    // Shift by DIST when this stage's amount bit is set.
    always_comb begin
        nxt_value = in_value;
        nxt_lost  = in_lost;
        dropped   = in_value >> (WIDTH - DIST);
        if (in_amt[BIT]) begin
            unique case (in_op)
                SHL: begin
                    nxt_value = in_value << DIST;
                    nxt_lost  = in_lost | (dropped != '0);
                end
                SHR: nxt_value = in_value >> DIST;
                SAR: nxt_value = WIDTH'($signed(in_value) >>> DIST);
                ROL: nxt_value = (in_value << DIST) | dropped;
            endcase
        end
    end

    // Slot register; loads whenever the slot is free to move.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            out_op    <= SHL;
            out_value <= '0;
            out_amt   <= '0;
            out_lost  <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_op    <= in_op;
                out_value <= nxt_value;
                out_amt   <= in_amt;
                out_lost  <= nxt_lost;
            end
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Pipelined shift unit: SHL/SHR/SAR/ROL over a log shifter.
// One op per cycle, results in order, lost-bit report on SHL.
module shift_unit
    import shift_pkg::*;
#(
    parameter int  WIDTH  = DEFAULT_WIDTH,
    localparam int STAGES = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input logic         clock,
    input logic         reset,
    shift_unit_if.slave bus
);

    logic [STAGES:0]    vld;
    logic [STAGES:0]    adv;
    shift_op_t          op_c   [STAGES+1];
    logic [WIDTH-1:0]   val_c  [STAGES+1];
    logic [STAGES-1:0]  amt_c  [STAGES+1];
    logic [STAGES:0]    lost_c;

    logic               over;
    logic               big;
    logic [WIDTH-1:0]   e_value;
    logic [STAGES-1:0]  e_amt;
    logic               e_lost;
    logic               unused_tail;

    // Entry: resolve over-range distances once, before stage 0.
    always_comb begin
        over    = bus.in_amount >= WIDTH'(WIDTH);
        big     = eff_amount(bus.in_op, over);
        e_value = bus.in_value;
        e_amt   = bus.in_amount[STAGES-1:0];
        e_lost  = 1'b0;
        if (big) begin
            e_amt   = '0;
            e_lost  = (bus.in_op == SHL) && (bus.in_value != '0);
            e_value = (bus.in_op == SAR) ?
                      {WIDTH{bus.in_value[WIDTH-1]}} : '0;
        end
    end

    assign vld[0]      = bus.in_valid;
    assign op_c[0]     = bus.in_op;
    assign val_c[0]    = e_value;
    assign amt_c[0]    = e_amt;
    assign lost_c[0]   = e_lost;
    assign adv[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .AW    (STAGES),
            .BIT   (k)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (vld[k]),
            .in_ready  (adv[k]),
            .in_op     (op_c[k]),
            .in_value  (val_c[k]),
            .in_amt    (amt_c[k]),
            .in_lost   (lost_c[k]),
            .out_valid (vld[k+1]),
            .out_ready (adv[k+1]),
            .out_op    (op_c[k+1]),
            .out_value (val_c[k+1]),
            .out_amt   (amt_c[k+1]),
            .out_lost  (lost_c[k+1])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld[STAGES];
    assign bus.out_value = val_c[STAGES];
    assign bus.out_lost  = lost_c[STAGES];

    assign unused_tail = ^{amt_c[STAGES], op_c[STAGES]};

endmodule

// File: tb/tb_shift_unit.sv
// Testbench for shift_unit: vector table, backpressure,
// random streaming against a reference model, reset mid-stream.
module tb_shift_unit;
    import shift_pkg::*;

    localparam int W = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    shift_unit_if #(.WIDTH(W)) bus ();

    shift_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] value;
        logic         lost;
    } res_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] val;
        logic [W-1:0] amt;
        logic [W-1:0] ev;
        logic         el;
    } vec_t;

    res_t sb[$];
    res_t exp_next;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc++;

    function automatic res_t model(input logic [1:0] op,
                                   input logic [W-1:0] v,
                                   input logic [W-1:0] a);
        res_t r;
        logic [2*W-1:0] f;
        int n;
        r.value = '0;
        r.lost  = 1'b0;
        f = '0;
        n = 0;
        case (op)
            2'd0: begin
                if (a >= 12'd12) begin
                    r.lost = (v != '0);
                end else begin
                    f = {{W{1'b0}}, v} << a;
                    r.value = f[W-1:0];
                    r.lost  = (f[2*W-1:W] != '0);
                end
            end
            2'd1: if (a < 12'd12) r.value = v >> a;
            2'd2: r.value = (a >= 12'd12) ? {W{v[W-1]}}
                                          : W'($signed(v) >>> a);
            default: begin
                n = int'(a[3:0]) % W;
                f = {v, v} << n;
                r.value = f[2*W-1:W];
            end
        endcase
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on delivery.
    always @(negedge clock) begin : mon
        res_t e;
        if (reset) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(exp_next);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h lost=%b need=none",
                             bus.out_value, bus.out_lost);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_value !== e.value || bus.out_lost !== e.lost) begin
                        errors++;
                        $display("FAIL result got=%h lost=%b need=%h lost=%b",
                                 bus.out_value, bus.out_lost, e.value, e.lost);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s got=%0h need=%0h", name, got, need);
        end
    endtask

    task automatic present(input logic [1:0] op, input logic [W-1:0] val,
                           input logic [W-1:0] amt, input res_t e);
        bus.in_op     = shift_op_t'(op);
        bus.in_value  = val;
        bus.in_amount = amt;
        exp_next      = e;
        bus.in_valid  = 1'b1;
    endtask

    task automatic wait_accept(output int waited);
        logic ok;
        waited = 0;
        forever begin
            @(negedge clock);
            ok = bus.in_ready;
            @(posedge clock);
            #1;
            if (ok) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got=%0d need<=50", waited);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] val,
                        input logic [W-1:0] amt, input res_t e,
                        output int waited);
        present(op, val, amt, e);
        wait_accept(waited);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   st, stalls, lat, p0, start;
        logic [W-1:0] hv;
        logic hl;
        logic [1:0] rop;
        logic [W-1:0] rval, ramt;

        tbl[0]  = '{2'd0, 12'h001, 12'd1,    12'h002, 1'b0};
        tbl[1]  = '{2'd0, 12'h8A5, 12'd3,    12'h528, 1'b1};
        tbl[2]  = '{2'd1, 12'h8A5, 12'd3,    12'h114, 1'b0};
        tbl[3]  = '{2'd2, 12'h8A5, 12'd3,    12'hF14, 1'b0};
        tbl[4]  = '{2'd3, 12'h8A5, 12'd3,    12'h52C, 1'b0};
        tbl[5]  = '{2'd0, 12'h801, 12'd12,   12'h000, 1'b1};
        tbl[6]  = '{2'd2, 12'h801, 12'd4095, 12'hFFF, 1'b0};
        tbl[7]  = '{2'd1, 12'h801, 12'd20,   12'h000, 1'b0};
        tbl[8]  = '{2'd3, 12'h801, 12'd13,   12'h003, 1'b0};
        tbl[9]  = '{2'd2, 12'h8A5, 12'd0,    12'h8A5, 1'b0};
        tbl[10] = '{2'd0, 12'h801, 12'd0,    12'h801, 1'b0};
        tbl[11] = '{2'd0, 12'h001, 12'd11,   12'h800, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_op     = SHL;
        bus.in_value  = '0;
        bus.in_amount = '0;
        bus.out_ready = 1'b0;
        exp_next      = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_value", bus.out_value, 0);
        check("rst_out_lost", bus.out_lost, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // latency of the first table vector
        bus.out_ready = 1'b1;
        send(tbl[0].op, tbl[0].val, tbl[0].amt, '{tbl[0].ev, tbl[0].el}, st);
        check("lat_stall", st, 0);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", lat, 4);
        drain();

        for (int i = 1; i < 12; i++) begin
            send(tbl[i].op, tbl[i].val, tbl[i].amt,
                 '{tbl[i].ev, tbl[i].el}, st);
        end
        drain();

        // backpressure: four fill the pipe, the fifth stalls
        bus.out_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            rval = 12'h8A5 ^ W'(i * 12'h111);
            ramt = W'(i + 1);
            rop  = 2'(i);
            send(rop, rval, ramt, model(rop, rval, ramt), st);
            stalls += st;
        end
        check("bp_fill_stalls", stalls, 0);
        present(2'd2, 12'hC03, 12'd2, model(2'd2, 12'hC03, 12'd2));
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        hv = bus.out_value;
        hl = bus.out_lost;
        repeat (3) @(posedge clock);
        #1;
        check("bp_hold_value", bus.out_value, hv);
        check("bp_hold_lost", bus.out_lost, hl);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        start = cyc;
        p0 = pops;
        wait_accept(st);
        check("bp_release_accept", st, 0);
        send(2'd3, 12'h0F1, 12'd7, model(2'd3, 12'h0F1, 12'd7), st);
        check("bp_sixth_accept", st, 0);
        while (cyc < start + 6) begin
            @(posedge clock);
            #1;
        end
        check("bp_six_in_six", pops - p0, 6);
        drain();

        // random streaming with output always ready
        stalls = 0;
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rval = W'($urandom);
            ramt = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                               : W'($urandom_range(0, 15));
            send(rop, rval, ramt, model(rop, rval, ramt), st);
            stalls += st;
        end
        check("stream_stalls", stalls, 0);
        drain();
        check("stream_count", pops - p0, 100);

        // reset with three ops in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rval = W'(12'h5A3 + i);
            send(2'd0, rval, 12'd1, model(2'd0, rval, 12'd1), st);
        end
        @(posedge clock);
        #1;
        check("mid_out_valid_pre", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        sb.delete();
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_out_value", bus.out_value, 0);
        check("mid_out_lost", bus.out_lost, 0);
        @(negedge clock);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        p0 = pops;
        repeat (10) @(posedge clock);
        #1;
        check("mid_no_stale", pops - p0, 0);
        check("mid_in_ready", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised, pipelined shift execution unit for the generated-program FPGA harness. It replaces the inline single-cycle `<<` used by the shiftLeft instruction with four modes: logical left, logical right, arithmetic right and rotate left. Any element width is supported, and the unit takes one operation per cycle through valid/ready handshakes. It sits between the instruction sequencer and local-memory write-back, and also reports lost bits on left shifts.

## Interface
- WIDTH, 12, operand/result width in bits; matches the memory element width.
- STAGES, $clog2(WIDTH), number of pipeline stages; derived, not overridden; minimum 1.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  shift_op_t: SHL=0, SHR=1, SAR=2, ROL=3.
- in_value  in  WIDTH  operand.
- in_amount  in  WIDTH  shift distance, unsigned, full element width.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_value  out  WIDTH  result.
- out_lost  out  1  SHL only: a 1 bit was shifted out. 0 for all other ops.

## Operation
- Uses a log shifter. Stage k shifts by 2^k when effective-amount bit k is set, and holds per-slot fields: valid, op, value, amount bits above k, and lost.
- Effective amount is computed once, at stage 0 entry:
  - SHL/SHR/SAR with in_amount >= WIDTH (big) is forced to full-range behaviour. SHL/SHR give 0. SAR gives all bits = in_value[WIDTH-1]. SHL lost = (in_value != 0).
  - For the remaining cases the amount is in_amount[STAGES-1:0].
  - ROL always uses in_amount[STAGES-1:0]. The result is a rotation by that value mod WIDTH; for WIDTH=12 an amount of 13 rotates by 1.
- Fill rules:
  - SHL fills with 0 at the LSB.
  - SHR fills with 0 at the MSB.
  - SAR fills with the original sign bit.
  - ROL wraps bits around.
- Lost flag: each stage ORs in any 1 bits leaving the MSB end on SHL. The flag is sticky through the pipe.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Stage k advances if it is empty or if stage k+1 advances.
  - The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. This is combinational, with no dependency on in_valid.
  - out_valid/out_value/out_lost are driven straight from last-stage registers; there is no combinational path from in_* to out_*.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - With out_ready held high, the unit sustains one result per cycle.
- Results emerge in acceptance order. Operations are never dropped or duplicated.

## Timing
- Reset (reset low, asynchronous): all stage valids clear to 0. out_valid=0, out_value=0, out_lost=0. in_ready=1 once reset is released.
- Reset mid-operation discards every in-flight operation. No partial result appears after release.
- Latency: an operation accepted on edge N makes out_valid go high after edge N+STAGES-1 (STAGES edges including N). For WIDTH=12 this is 4 cycles.
- Full pipe with out_ready=0: in_ready drops combinationally once stage 0 is occupied and cannot advance.
- Simultaneous output consume and input accept in a full pipe: both occur on the same edge, and throughput is kept.
- Amount 0: value passes through unchanged, lost=0, same latency.

## Structure
- shift_pkg:
  - shift_op_t enum.
  - Function eff_amount(op, amount) returning the forced/big decision.
  - Constant for default WIDTH.
- Sub-module shift_stage (parameters WIDTH, DIST):
  - One registered slot.
  - Applies a conditional shift by DIST for all four ops.
  - Accumulates lost.
  - Implements the advance/valid logic.
- shift_unit instantiates STAGES shift_stage instances in a generate loop with DIST=2^k.

## Test plan
- Harness equivalence: SHL value=1, amount=1 -> out_value=2, lost=0, out_valid exactly 4 cycles after accept (WIDTH=12).
- Mode sweep, WIDTH=12, value=12'h8A5, amount=3:
  - SHL -> 12'h528, lost=1.
  - SHR -> 12'h114.
  - SAR -> 12'hF14.
  - ROL -> 12'h52C.
- Over-range, value=12'h801:
  - SHL amount=12 -> 0, lost=1.
  - SAR amount=4095 -> 12'hFFF.
  - SHR amount=20 -> 0.
  - ROL amount=13 -> 12'h003.
- Backpressure: issue 6 ops back-to-back with out_ready=0.
  - in_ready falls after 4 accepts.
  - out_* stays stable.
  - Release gives 6 results in order, one per cycle.
- Streaming: 100 random ops with out_ready=1 -> one result per cycle, each matching the reference model.
- Reset mid-stream: assert reset with 3 ops in flight -> out_valid=0 immediately, and no stale result after release.
